// File: rtl/spi_slave.sv
// SPI slave front-end: deserialises 10-bit command frames for the RAM and serialises read data back on MISO.
// Optional frame_err abort strobe is built only when SPI_FRAME_ERR_EN is defined.
module spi_slave #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic                 frame_err
`endif
);

    localparam int CW    = ADDR_SIZE + 2;
    localparam int CNT_W = $clog2(CW + 1);
    localparam int TX_W  = $clog2(ADDR_SIZE + 1);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t                state;
    logic [CW-1:0]         shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  rx_done;
    logic                  rd_addr_seen;
    logic [ADDR_SIZE-1:0]  tx_shift;
    logic [TX_W-1:0]       tx_cnt;
    logic                  tx_busy;
    logic                  tx_done;

    logic last_bit;
    logic byte_done;
    logic frame_ok;

    // last_bit: this edge samples the final command-word bit.
    // byte_done: the LSB has already been on MISO for a full cycle.
    assign last_bit  = (state == WRITE || state == READ_ADD || state == READ_DATA)
                       && !rx_done && (bit_cnt == CNT_W'(CW - 1));
    assign byte_done = tx_busy && (tx_cnt == TX_W'(ADDR_SIZE));
    assign frame_ok  = last_bit ? (state != READ_DATA)
                                : (rx_done && (state != READ_DATA || tx_done || byte_done));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            rx_done      <= 1'b0;
            rd_addr_seen <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            MISO         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err    <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            if (state == IDLE) begin
                bit_cnt <= '0;
                rx_done <= 1'b0;
                tx_busy <= 1'b0;
                tx_done <= 1'b0;
                MISO    <= 1'b0;
                if (!SS_n)
                    state <= CHK_CMD;
            end else if (SS_n) begin
                // A final bit sampled together with SS_n rising still completes the frame.
                state   <= IDLE;
                bit_cnt <= '0;
                tx_busy <= 1'b0;
                MISO    <= 1'b0;
                if (last_bit) begin
                    rx_data  <= {shift_reg[CW-2:0], MOSI};
                    rx_valid <= 1'b1;
                    if (state == READ_ADD)
                        rd_addr_seen <= 1'b1;
                end
                if (byte_done)
                    rd_addr_seen <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
                frame_err <= !frame_ok;
`endif
            end else begin
                case (state)
                    CHK_CMD: begin
                        shift_reg <= {shift_reg[CW-2:0], MOSI};
                        bit_cnt   <= CNT_W'(1);
                        if (!MOSI)
                            state <= WRITE;
                        else if (rd_addr_seen)
                            state <= READ_DATA;
                        else
                            state <= READ_ADD;
                    end
                    default: begin
                        if (!rx_done) begin
                            shift_reg <= {shift_reg[CW-2:0], MOSI};
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (last_bit) begin
                                rx_data  <= {shift_reg[CW-2:0], MOSI};
                                rx_valid <= 1'b1;
                                rx_done  <= 1'b1;
                                if (state == READ_ADD)
                                    rd_addr_seen <= 1'b1;
                            end
                        end else if (state == READ_DATA && !tx_done) begin
                            if (!tx_busy) begin
                                if (tx_valid) begin
                                    MISO     <= tx_data[ADDR_SIZE-1];
                                    tx_shift <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                                    tx_cnt   <= TX_W'(1);
                                    tx_busy  <= 1'b1;
                                end
                            end else if (byte_done) begin
                                MISO         <= 1'b0;
                                tx_busy      <= 1'b0;
                                tx_done      <= 1'b1;
                                rd_addr_seen <= 1'b0;
                            end else begin
                                MISO     <= tx_shift[ADDR_SIZE-1];
                                tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
                                tx_cnt   <= tx_cnt + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    logic unused_frame_ok;
    assign unused_frame_ok = frame_ok;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: frames driven on negedge, outputs checked on negedge.
module tb_spi_slave;
    localparam int AS = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          SS_n;
    logic          MOSI;
    logic          MISO;
    logic [AS+1:0] rx_data;
    logic          rx_valid;
    logic [AS-1:0] tx_data;
    logic          tx_valid;
`ifdef SPI_FRAME_ERR_EN
    logic          frame_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_slave #(.ADDR_SIZE(AS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    // Frame edges 0..10; returns at the negedge after edge 11.
    task automatic send_frame(input logic [9:0] w, input bit ss_on_last);
        bit early = 1'b0;
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rx_valid !== 1'b0) early = 1'b1;
            MOSI = w[9-i];
            if (ss_on_last && i == 9) SS_n = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (early) begin
            failures++;
            $display("FAIL early_rx_valid frame=%h: rx_valid seen before final bit", w);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== w) begin
            failures++;
            $display("FAIL frame_result: rx_valid=%b rx_data=%h, expected 1 / %h", rx_valid, rx_data, w);
        end
`ifdef SPI_FRAME_ERR_EN
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_complete: got %b expected 0", frame_err);
        end
`endif
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL rx_valid_width: got %b expected 0", rx_valid);
        end
    endtask

    task automatic end_frame(input logic exp_err);
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
`ifdef SPI_FRAME_ERR_EN
        checks++;
        if (frame_err !== exp_err) begin
            failures++;
            $display("FAIL frame_err_end: got %b expected %b", frame_err, exp_err);
        end
`else
        if (exp_err) begin end
`endif
    endtask

    // In READ_ADD/WRITE a tx_valid must not produce any MISO activity.
    task automatic no_response(input string name);
        bit bad = 1'b0;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            MOSI = ~MOSI;
            if (MISO !== 1'b0 || rx_valid !== 1'b0) bad = 1'b1;
        end
        tx_valid = 1'b0;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s: MISO/rx_valid active, expected both 0", name);
        end
    endtask

    task automatic shift_check(input logic [7:0] d);
        bit bad = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            @(negedge clk);
            tx_valid = 1'b0;
            checks++;
            if (MISO !== d[k]) begin
                failures++;
                $display("FAIL miso_bit%0d data=%h: got %b expected %b", k, d, MISO, d[k]);
            end
        end
        @(negedge clk);
        checks++;
        if (MISO !== 1'b0) begin
            failures++;
            $display("FAIL miso_after_lsb: got %b expected 0", MISO);
        end
        tx_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (MISO !== 1'b0) bad = 1'b1;
        end
        tx_valid = 1'b0;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL miso_retrigger: MISO active, expected 0");
        end
    endtask

    task automatic abort_frame(input logic [4:0] bits);
        bit bad = 1'b0;
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rx_valid !== 1'b0) bad = 1'b1;
            MOSI = bits[4-i];
        end
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
        if (rx_valid !== 1'b0) bad = 1'b1;
`ifdef SPI_FRAME_ERR_EN
        checks++;
        if (frame_err !== 1'b1) begin
            failures++;
            $display("FAIL frame_err_pulse: got %b expected 1", frame_err);
        end
`endif
        @(negedge clk);
        if (rx_valid !== 1'b0) bad = 1'b1;
`ifdef SPI_FRAME_ERR_EN
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_width: got %b expected 0", frame_err);
        end
`endif
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL abort_rx_valid: rx_valid asserted, expected 0");
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
            failures++;
            $display("FAIL reset_outputs: MISO=%b rx_valid=%b rx_data=%h, expected 0/0/000", MISO, rx_valid, rx_data);
        end
`ifdef SPI_FRAME_ERR_EN
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_frame_err: got %b expected 0", frame_err);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_write_addr;
        send_frame(10'h05A, 1'b0);
        no_response("write_hold_low");
        end_frame(1'b0);
    endtask

    task automatic test_write_data;
        send_frame(10'h1C3, 1'b0);
        end_frame(1'b0);
    endtask

    task automatic test_read;
        send_frame(10'h25A, 1'b0);
        no_response("read_addr_no_miso");
        end_frame(1'b0);
        send_frame(10'h300, 1'b0);
        shift_check(8'hC3);
        end_frame(1'b0);
        send_frame(10'h2FF, 1'b0);
        no_response("flag_cleared_read_add");
        end_frame(1'b0);
        send_frame(10'h3AB, 1'b0);
        shift_check(8'h5A);
        end_frame(1'b0);
    endtask

    task automatic test_ss_on_last;
        send_frame(10'h0F0, 1'b1);
        end_frame(1'b0);
    endtask

    task automatic test_abort;
        abort_frame(5'b00010);
        send_frame(10'h133, 1'b0);
        end_frame(1'b0);
        send_frame(10'h25A, 1'b0);
        end_frame(1'b0);
        abort_frame(5'b11000);
        send_frame(10'h300, 1'b0);
        shift_check(8'h96);
        end_frame(1'b0);
    endtask

    task automatic test_back_to_back;
        send_frame(10'h0AA, 1'b0);
        end_frame(1'b0);
        send_frame(10'h155, 1'b0);
        end_frame(1'b0);
    endtask

    task automatic test_reset_mid_shift;
        send_frame(10'h25A, 1'b0);
        end_frame(1'b0);
        send_frame(10'h300, 1'b0);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        SS_n  = 1'b1;
        @(negedge clk);
        checks++;
        if (MISO !== 1'b0 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_shift: MISO=%b rx_valid=%b expected 0/0", MISO, rx_valid);
        end
        rst_n = 1'b1;
        send_frame(10'h3C0, 1'b0);
        no_response("reset_clears_flag");
        end_frame(1'b0);
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_write_data();
        test_read();
        test_ss_on_last();
        test_abort();
        test_back_to_back();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave front-end that converts serial master transactions into parallel command words for the single-port RAM and serialises RAM read data back to the master. It sits between the SPI pins (SS_n, MOSI, MISO) and the RAM's din/rx_valid/dout/tx_valid interface. It is the initiator side of that interface: it issues write-address, write-data, read-address and read-data commands, and consumes the RAM's read response.

## Interface
- ADDR_SIZE, 8: RAM address/data width. The command word is ADDR_SIZE+2 bits.
- clk  in  1  SPI clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- SS_n  in  1  slave select, active low; frames a transaction.
- MOSI  in  1  serial data from master, MSB first.
- MISO  out  1  serial read data to master, MSB first.
- rx_data  out  ADDR_SIZE+2  command word to RAM din; bits [ADDR_SIZE+1:ADDR_SIZE] = command.
- rx_valid  out  1  one-cycle strobe; rx_data valid.
- tx_data  in  ADDR_SIZE  RAM read data (RAM dout).
- tx_valid  in  1  RAM read data valid.
- frame_err  out  1  only with SPI_FRAME_ERR_EN; see Configuration.

## Operation
- Commands are carried in rx_data[ADDR_SIZE+1:ADDR_SIZE]:
  - 00: write address.
  - 01: write data.
  - 10: read address.
  - 11: read data.
- States:
  - IDLE: SS_n=0 → CHK_CMD; otherwise stay.
  - CHK_CMD: samples MOSI as command bit [ADDR_SIZE+1] and shifts it into the receive register.
    - MOSI=0 → WRITE.
    - MOSI=1 and rd_addr_seen=0 → READ_ADD.
    - MOSI=1 and rd_addr_seen=1 → READ_DATA.
  - WRITE, READ_ADD, READ_DATA: shift the remaining ADDR_SIZE+1 MOSI bits, MSB first, with a bit counter.
- On the posedge that samples the final (10th) bit:
  - Load rx_data from the shift register and assert rx_valid for exactly one cycle.
  - Stop shifting. Extra MOSI bits in the same frame are ignored.
- rd_addr_seen flag:
  - Set when a READ_ADD frame completes, i.e. rx_valid is issued.
  - Cleared when a READ_DATA frame has shifted out its full byte.
  - Unaffected by write frames and by aborted frames.
- READ_DATA response:
  - After rx_valid, wait for tx_valid=1.
  - On the first posedge with tx_valid=1, capture tx_data and drive MISO = tx_data[ADDR_SIZE-1].
  - On each following posedge, drive the next lower bit.
  - After the LSB has been driven for one cycle, MISO returns to 0 and further tx_valid is ignored until the next frame.
- SS_n=1 in any non-IDLE state → IDLE on the next posedge. On that transition:
  - Bit counter cleared; MISO=0.
  - No rx_valid is issued for an incomplete frame.
- MISO is 0 whenever it is not actively shifting read data.

## Timing
- Reset values: MISO=0, rx_valid=0, rx_data=0, frame_err=0. Internal: state IDLE, rd_addr_seen=0, counters 0.
- Reset is synchronous and overrides all activity mid-frame. rd_addr_seen clears on reset.
- Frame timeline (edge 0 = first posedge seeing SS_n=0):
  - Edge 0: IDLE → CHK_CMD.
  - Edges 1..10: sample bits [ADDR_SIZE+1]..[0].
  - Edge 10: rx_valid is registered; it is high during the cycle after edge 10.
- Latency from the last MOSI bit to rx_valid high: 1 cycle.
- With the standard RAM, tx_valid rises 1 cycle after rx_valid. The first MISO bit is then driven at the next posedge, and bits follow on consecutive cycles (ADDR_SIZE cycles total).
- Simultaneous events:
  - SS_n rising on the same posedge as the final bit sample: the frame counts as complete and rx_valid is issued.
  - SS_n rising during MISO shifting: shifting stops and rd_addr_seen is not cleared.
- SS_n held low after a completed frame: remain in the terminal state, idle, until SS_n=1.

## Configuration
- Macro: SPI_FRAME_ERR_EN.
- Defined:
  - Adds the frame_err output.
  - frame_err pulses high for one cycle on the posedge where SS_n=1 is seen in a non-IDLE state before frame completion.
  - Frame completion means rx_valid issued, and for READ_DATA, all ADDR_SIZE MISO bits shifted.
- Not defined: port and logic absent; abort behaviour is otherwise identical.

## Test plan
- Write address: frame 00_0101_1010 → one rx_valid pulse with rx_data=0x05A; MISO stays 0.
- Write data: frame 01_1100_0011 → rx_data=0x1C3; rd_addr_seen stays 0.
- Read address: frame 10_0101_1010 → rx_data=0x25A; the next frame starting with MOSI=1 enters READ_DATA.
- Read data: frame 11_xxxx_xxxx after a read address, tx_valid=1 with tx_data=0xC3 one cycle after rx_valid → MISO=1,1,0,0,0,0,1,1 on consecutive cycles, then 0. The next read frame enters READ_ADD.
- Abort: SS_n=1 after 5 bits of a write frame → no rx_valid; state IDLE next cycle; frame_err one-cycle pulse when SPI_FRAME_ERR_EN is defined.
- Reset: rst_n=0 during MISO shifting → MISO=0, rx_valid=0 next posedge; a subsequent MOSI=1 frame enters READ_ADD.
